// File: rtl/vx_raster_req_packer.sv
// vx_raster_req_packer: raster-unit master of the raster bus.
// Packs rasterizer stamps into NUM_LANES-wide requests for one core,
// flushes partial packets on idle timeout or end of work, and then
// presents a sticky done packet until the next start pulse.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             pulse: begin new work, leave the done state
//   stamp_valid       input stamp offered
//   stamp_data        input stamp {pos_x, pos_y, mask, pid, bcoords}
//   stamp_ready       input stamp accepted this cycle
//   raster_done       level: rasterizer issues no more stamps
//   req_valid         bus request valid (registered)
//   req_stamps        lane i at [i*STAMP_WIDTH +: STAMP_WIDTH]
//   req_done          no more work; stamps all zero
//   req_ready         bus request consumed
//   busy              accumulator or data packet non-empty

module vx_raster_req_packer #(
    parameter int NUM_LANES    = 4,
    parameter int STAMP_WIDTH  = 64,
    parameter int FLUSH_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             stamp_valid,
    input  logic [STAMP_WIDTH-1:0]           stamp_data,
    output logic                             stamp_ready,
    input  logic                             raster_done,
    output logic                             req_valid,
    output logic [NUM_LANES*STAMP_WIDTH-1:0] req_stamps,
    output logic                             req_done,
    input  logic                             req_ready,
    output logic                             busy
);

    localparam int CW = $clog2(NUM_LANES + 1);
    localparam int IW = $clog2(FLUSH_CYCLES + 1);
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    localparam logic [CW-1:0] FULL     = CW'(NUM_LANES);
    localparam logic [IW-1:0] IDLE_MAX = IW'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DONE
    } state_t;

    state_t state;
    state_t state_n;

    logic [STAMP_WIDTH-1:0]           lanes [NUM_LANES];
    logic [CW-1:0]                    count;
    logic [IW-1:0]                    idle;
    logic [LW-1:0]                    wr_idx;
    logic                             accept;
    logic                             out_free;
    logic                             move_cond;
    logic                             move;
    logic [NUM_LANES*STAMP_WIDTH-1:0] packed_lanes;

    // ------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // ------------------------------------------------------------
    // FSM next state and input-side handshake
    // ------------------------------------------------------------
    always_comb begin
        state_n     = state;
        stamp_ready = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_FILL;
                end
            end
            S_FILL: begin
                stamp_ready = (count < FULL);
                // Enter done only once every buffered stamp has been
                // handed over and no stamp is being taken this cycle.
                if ((count == '0) && !req_valid && raster_done &&
                    !stamp_valid) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_n = S_FILL;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign accept   = stamp_valid && stamp_ready;
    assign out_free = !req_valid || req_ready;
    assign wr_idx   = LW'(count);

    // A packet leaves when full, or partially filled and either the
    // idle timer expired or the rasterizer has nothing more to give.
    always_comb begin
        move_cond = 1'b0;
        if (state == S_FILL) begin
            if (count == FULL) begin
                move_cond = 1'b1;
            end else if (count != '0) begin
                move_cond = (idle == IDLE_MAX) ||
                            (raster_done && !stamp_valid);
            end
        end
    end

    assign move = move_cond && out_free;

    // Lanes at or beyond count carry stale data; zero them on output.
    always_comb begin
        packed_lanes = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (CW'(i) < count) begin
                packed_lanes[i*STAMP_WIDTH +: STAMP_WIDTH] = lanes[i];
            end
        end
    end

    // ------------------------------------------------------------
    // Accumulator
    // ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                lanes[i] <= '0;
            end
        end else if (move) begin
            // The emptied accumulator takes a same-cycle stamp in lane 0.
            if (accept) begin
                lanes[0] <= stamp_data;
                count    <= CW'(1);
            end else begin
                count    <= '0;
            end
        end else if (accept) begin
            lanes[wr_idx] <= stamp_data;
            count         <= count + CW'(1);
        end
    end

    // ------------------------------------------------------------
    // Idle timer, saturating at FLUSH_CYCLES
    // ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            idle <= '0;
        end else if (move || accept || (count == '0)) begin
            idle <= '0;
        end else if (idle != IDLE_MAX) begin
            idle <= idle + IW'(1);
        end
    end

    // ------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            req_valid  <= 1'b0;
            req_done   <= 1'b0;
            req_stamps <= '0;
        end else if (state == S_DONE) begin
            // Sticky done: every pop sees the same done packet.
            if (start) begin
                req_valid <= 1'b0;
                req_done  <= 1'b0;
            end else begin
                req_valid <= 1'b1;
                req_done  <= 1'b1;
            end
            req_stamps <= '0;
        end else if (state_n == S_DONE) begin
            req_valid  <= 1'b1;
            req_done   <= 1'b1;
            req_stamps <= '0;
        end else if (move) begin
            req_valid  <= 1'b1;
            req_done   <= 1'b0;
            req_stamps <= packed_lanes;
        end else if (req_ready) begin
            req_valid  <= 1'b0;
        end
    end

    assign busy = (count != '0) || (req_valid && !req_done);

endmodule

// File: tb/tb_vx_raster_req_packer.sv
// tb_vx_raster_req_packer: directed and randomized checks of the
// raster request packer against a queue-based ordering model.

module tb_vx_raster_req_packer;

    localparam int NL = 4;
    localparam int SW = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              stamp_valid;
    logic [SW-1:0]     stamp_data;
    logic              stamp_ready;
    logic              raster_done;
    logic              req_valid;
    logic [NL*SW-1:0]  req_stamps;
    logic              req_done;
    logic              req_ready;
    logic              busy;

    int vectors = 0;
    int miscompares = 0;

    logic [NL*SW-1:0] pkts [$];
    logic [SW-1:0]    exp_q [$];

    vx_raster_req_packer #(
        .NUM_LANES(NL),
        .STAMP_WIDTH(SW),
        .FLUSH_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .stamp_valid(stamp_valid),
        .stamp_data(stamp_data),
        .stamp_ready(stamp_ready),
        .raster_done(raster_done),
        .req_valid(req_valid),
        .req_stamps(req_stamps),
        .req_done(req_done),
        .req_ready(req_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Record every data packet the bus consumes.
    always @(negedge clk) begin
        if (!reset && req_valid && req_ready && !req_done) begin
            pkts.push_back(req_stamps);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [NL*SW-1:0] obs,
                       input logic [NL*SW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SW-1:0] mk(input int p);
        if (p == 0) return '0;
        return {16'(p * 3), 16'(p * 5), 4'hF, 12'(p), 16'hBEEF};
    endfunction

    function automatic logic [NL*SW-1:0] pk(input int a, input int b,
                                            input int c, input int d);
        return {mk(d), mk(c), mk(b), mk(a)};
    endfunction

    // Offer one stamp and return just after the edge that takes it.
    task automatic send(input logic [SW-1:0] d);
        int k;
        stamp_valid = 1'b1;
        stamp_data  = d;
        for (k = 0; k < 64; k++) begin
            if (stamp_ready) break;
            step();
        end
        chk("send_ready", stamp_ready, 1);
        step();
    endtask

    initial begin
        int n;
        int sent;
        int gap;
        bit hold;
        bit seen;
        logic [NL*SW-1:0] first_pkt;
        logic [NL*SW-1:0] pv;
        logic [SW-1:0]    cur;
        int k;

        reset       = 1'b1;
        start       = 1'b0;
        stamp_valid = 1'b0;
        stamp_data  = '0;
        raster_done = 1'b0;
        req_ready   = 1'b0;
        step();
        step();
        chk("rst_valid", req_valid, 0);
        chk("rst_done", req_done, 0);
        chk("rst_stamps", req_stamps, 0);
        chk("rst_sready", stamp_ready, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;

        // Stamps offered while idle are not taken.
        stamp_valid = 1'b1;
        stamp_data  = mk(9);
        step();
        chk("idle_sready", stamp_ready, 0);
        chk("idle_busy", busy, 0);
        stamp_valid = 1'b0;

        // Full packet, full rate.
        start = 1'b1;
        step();
        start = 1'b0;
        req_ready = 1'b1;
        chk("fill_sready", stamp_ready, 1);
        for (int i = 1; i <= 4; i++) send(mk(i));
        stamp_valid = 1'b0;
        chk("full_wait_valid", req_valid, 0);
        chk("full_sready", stamp_ready, 0);
        chk("full_busy", busy, 1);
        step();
        chk("full_valid", req_valid, 1);
        chk("full_data", req_stamps, pk(1, 2, 3, 4));
        chk("full_done", req_done, 0);
        step();
        chk("full_popped", req_valid, 0);

        // Six stamps then idle flush.
        pkts.delete();
        for (int i = 1; i <= 6; i++) send(mk(i));
        stamp_valid = 1'b0;
        repeat (16) step();
        chk("flush_early", req_valid, 0);
        step();
        chk("flush_valid", req_valid, 1);
        chk("flush_data", req_stamps, pk(5, 6, 0, 0));
        step();
        chk("flush_npkts", pkts.size(), 2);
        if (pkts.size() == 2) begin
            chk("flush_pkt0", pkts[0], pk(1, 2, 3, 4));
            chk("flush_pkt1", pkts[1], pk(5, 6, 0, 0));
        end

        // Backpressure with 12 stamps.
        pkts.delete();
        req_ready = 1'b0;
        n = 1;
        seen = 1'b0;
        first_pkt = '0;
        for (int c = 0; c < 10; c++) begin
            stamp_valid = 1'b1;
            stamp_data  = mk(n);
            hold = stamp_ready;
            step();
            if (hold) n++;
            if (req_valid) begin
                if (!seen) begin
                    first_pkt = req_stamps;
                    seen = 1'b1;
                end else begin
                    chk("bp_stable", req_stamps, first_pkt);
                end
            end
        end
        chk("bp_accepted", n - 1, 8);
        chk("bp_sready", stamp_ready, 0);
        chk("bp_valid", req_valid, 1);
        chk("bp_data", req_stamps, pk(1, 2, 3, 4));
        req_ready = 1'b1;
        for (int c = 0; c < 60 && n <= 12; c++) begin
            stamp_valid = 1'b1;
            stamp_data  = mk(n);
            hold = stamp_ready;
            step();
            if (hold) n++;
        end
        stamp_valid = 1'b0;
        repeat (10) step();
        chk("bp_npkts", pkts.size(), 3);
        if (pkts.size() == 3) begin
            chk("bp_pkt0", pkts[0], pk(1, 2, 3, 4));
            chk("bp_pkt1", pkts[1], pk(5, 6, 7, 8));
            chk("bp_pkt2", pkts[2], pk(9, 10, 11, 12));
        end

        // Partial packet on end of work, then sticky done.
        pkts.delete();
        for (int i = 1; i <= 3; i++) send(mk(i));
        stamp_valid = 1'b0;
        raster_done = 1'b1;
        step();
        chk("end_valid", req_valid, 1);
        chk("end_data", req_stamps, pk(1, 2, 3, 0));
        chk("end_done", req_done, 0);
        step();
        chk("end_gap_valid", req_valid, 0);
        chk("end_gap_done", req_done, 0);
        step();
        chk("done_valid", req_valid, 1);
        chk("done_flag", req_done, 1);
        chk("done_stamps", req_stamps, 0);
        chk("done_busy", busy, 0);
        for (int i = 0; i < 5; i++) begin
            stamp_valid = 1'b1;
            stamp_data  = mk(7);
            step();
            chk("done_pop_valid", req_valid, 1);
            chk("done_pop_flag", req_done, 1);
            chk("done_pop_stamps", req_stamps, 0);
            chk("done_sready", stamp_ready, 0);
        end
        chk("done_npkts", pkts.size(), 1);
        stamp_valid = 1'b0;
        raster_done = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_valid", req_valid, 0);
        chk("restart_done", req_done, 0);
        chk("restart_sready", stamp_ready, 1);

        // Random scoreboard: 1000 stamps, random valid and ready.
        pkts.delete();
        exp_q.delete();
        sent = 0;
        gap = 0;
        cur = {$urandom, $urandom} | 64'h1;
        for (int c = 0; c < 20000 && sent < 1000; c++) begin
            if (gap > 0) begin
                stamp_valid = 1'b0;
                gap--;
            end else begin
                stamp_valid = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 59) == 0)
                    gap = $urandom_range(14, 20);
            end
            stamp_data = cur;
            req_ready  = ($urandom_range(0, 9) < 6);
            hold = stamp_valid && stamp_ready;
            step();
            if (hold) begin
                exp_q.push_back(cur);
                sent++;
                cur = {$urandom, $urandom} | 64'h1;
            end
        end
        chk("rnd_sent", sent, 1000);
        stamp_valid = 1'b0;
        req_ready = 1'b1;
        repeat (40) step();
        foreach (pkts[p]) begin
            pv = pkts[p];
            k = 0;
            for (int i = 0; i < NL; i++) begin
                if (pv[i*SW +: SW] != '0) k = i + 1;
            end
            chk("rnd_nonempty", k > 0, 1);
            for (int i = 0; i < k; i++) begin
                chk("rnd_have_exp", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    chk("rnd_lane", pv[i*SW +: SW], exp_q.pop_front());
                end
            end
        end
        chk("rnd_all_delivered", exp_q.size(), 0);
        chk("rnd_busy", busy, 0);

        // Reset mid-operation discards everything.
        pkts.delete();
        req_ready = 1'b0;
        for (int i = 1; i <= 6; i++) send(mk(i));
        stamp_valid = 1'b0;
        chk("mid_valid", req_valid, 1);
        chk("mid_busy", busy, 1);
        reset = 1'b1;
        step();
        chk("mid_rst_valid", req_valid, 0);
        chk("mid_rst_done", req_done, 0);
        chk("mid_rst_stamps", req_stamps, 0);
        chk("mid_rst_sready", stamp_ready, 0);
        chk("mid_rst_busy", busy, 0);
        reset = 1'b0;
        req_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (req_valid) seen = 1'b1;
        end
        chk("post_rst_no_valid", seen, 0);
        chk("post_rst_npkts", pkts.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
